// File: rtl/ex_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ex_mdu_pkg
//   Shared MDU opcode encodings. The controller uses the same encodings for
//   ALUop/MDU decode, so the numeric values are fixed and must not move.
//   Also provides a helper that classifies the multi-cycle arithmetic ops.
// ---------------------------------------------------------------------------
package ex_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MFHI     = 4'd7,
        MFLO     = 4'd8
    } mdu_op_e;

    localparam int MDU_OP_W = 4;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_arith_op(input logic [MDU_OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// ---------------------------------------------------------------------------
// ex_mdu_if
//   Bundle between the EX stage / hazard unit and the multiply-divide unit.
//   master : E-stage side (drives op, operands, start, flush; reads results)
//   slave  : the MDU itself
//   Signals:
//     start    E-stage instr is mult/multu/div/divu (one pulse per instr)
//     mdu_op   MDU opcode (ex_mdu_pkg encoding)
//     rs_val   forwarded Read1_E
//     rt_val   forwarded Read2_E
//     flush    exception/interrupt this cycle; cancels E-stage MDU effects
//     busy     registered, high while an op is in flight
//     hi, lo   architectural HI/LO
//     mdu_out  combinational MFHI/MFLO read data
// ---------------------------------------------------------------------------
interface ex_mdu_if;
    import ex_mdu_pkg::*;

    logic                start;
    logic [MDU_OP_W-1:0] mdu_op;
    logic [31:0]         rs_val;
    logic [31:0]         rt_val;
    logic                flush;
    logic                busy;
    logic [31:0]         hi;
    logic [31:0]         lo;
    logic [31:0]         mdu_out;

    modport master (
        output start, mdu_op, rs_val, rt_val, flush,
        input  busy, hi, lo, mdu_out
    );

    modport slave (
        input  start, mdu_op, rs_val, rt_val, flush,
        output busy, hi, lo, mdu_out
    );

endinterface

// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu
//   Multi-cycle multiply/divide unit of the EX stage. Owns HI/LO.
//   The 64-bit result is computed at the accepting edge and parked in temp
//   registers; HI/LO are written only when the busy countdown expires, so
//   the new values appear in the same cycle busy falls.
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>=1)
//   DIV_CYCLES   busy cycles for div/divu  (>=1)
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state
//   bus    ex_mdu_if.slave (start, mdu_op, rs_val, rt_val, flush,
//          busy, hi, lo, mdu_out)
// ---------------------------------------------------------------------------
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    ex_mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // Counter only ever holds N-1.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      temp_hi_reg;
    logic [31:0]      temp_lo_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    logic             accept;
    logic             is_div;
    logic [63:0]      result_next;

    logic signed [63:0] mult_s;
    logic        [63:0] mult_u;
    logic        [31:0] div_q_s;
    logic        [31:0] div_r_s;
    logic        [31:0] div_q_u;
    logic        [31:0] div_r_u;

    assign accept = (state_reg == S_IDLE) & bus.start & ~bus.flush & is_arith_op(bus.mdu_op);
    assign is_div = (bus.mdu_op == DIV) || (bus.mdu_op == DIVU);

    // Full-width sign extension keeps the signed product exact in 64 bits.
    assign mult_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val})
                  * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    assign mult_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};

    // Signed divide is done at 33 bits so 0x80000000 / -1 does not overflow;
    // the low 32 bits of +2^31 give 0x80000000, remainder 0.
    assign div_q_s = 32'($signed({bus.rs_val[31], bus.rs_val}) / $signed({bus.rt_val[31], bus.rt_val}));
    assign div_r_s = 32'($signed({bus.rs_val[31], bus.rs_val}) % $signed({bus.rt_val[31], bus.rt_val}));
    assign div_q_u = bus.rs_val / bus.rt_val;
    assign div_r_u = bus.rs_val % bus.rt_val;

    // Divide by zero parks the current HI/LO, so completion rewrites them
    // unchanged (nothing else can modify HI/LO while busy).
    always_comb begin
        result_next = {hi_reg, lo_reg};
        case (bus.mdu_op)
            MULT:    result_next = mult_s;
            MULTU:   result_next = mult_u;
            DIV:     if (bus.rt_val != 32'd0) result_next = {div_r_s, div_q_s};
            DIVU:    if (bus.rt_val != 32'd0) result_next = {div_r_u, div_q_u};
            default: result_next = {hi_reg, lo_reg};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            temp_hi_reg <= '0;
            temp_lo_reg <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        temp_hi_reg <= result_next[63:32];
                        temp_lo_reg <= result_next[31:0];
                        count_reg   <= is_div ? DIV_LOAD : MULT_LOAD;
                        state_reg   <= S_BUSY;
                    end else if (!bus.flush) begin
                        if (bus.mdu_op == MTHI) hi_reg <= bus.rs_val;
                        if (bus.mdu_op == MTLO) lo_reg <= bus.rs_val;
                    end
                end
                default: begin
                    // In-flight op ignores flush: its instruction already left E.
                    if (count_reg == '0) begin
                        hi_reg    <= temp_hi_reg;
                        lo_reg    <= temp_lo_reg;
                        state_reg <= S_IDLE;
                    end else begin
                        count_reg <= count_reg - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.busy    = (state_reg == S_BUSY);
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;
    assign bus.mdu_out = (bus.mdu_op == MFHI) ? hi_reg :
                         (bus.mdu_op == MFLO) ? lo_reg : 32'd0;

endmodule
